// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sharing one XOR/ADD/NAND ALU.
// Each operation is granted in IDLE, computed in EXEC and held in RESP until accepted.
module alu_arbiter #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic [1:0]  i_req0_opcode,
    input  logic [7:0]  i_req0_a,
    input  logic [7:0]  i_req0_b,

    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic [1:0]  i_req1_opcode,
    input  logic [7:0]  i_req1_a,
    input  logic [7:0]  i_req1_b,

    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic        o_rsp_id,
    output logic [7:0]  o_rsp_data,

    output logic        o_busy,
    output logic [15:0] o_done_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio;
    logic [1:0]  r_op;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic        r_id;
    logic [7:0]  r_rsp_data;
    logic        r_rsp_id;
    logic [15:0] r_done_cnt;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_rsp_fire;
    logic [7:0]  w_alu;

    // Arbitration and next state; grants can only be raised while idle.
    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_req0_valid && (!i_req1_valid || (r_prio == 1'b0))) begin
                    w_grant0 = 1'b1;
                end else if (i_req1_valid) begin
                    w_grant1 = 1'b1;
                end
                if (w_grant0 || w_grant1) begin
                    w_state_nxt = StExec;
                end
            end
            StExec: begin
                w_state_nxt = StResp;
            end
            StResp: begin
                if (i_rsp_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_comb begin
        unique case (r_op)
            2'b00:   w_alu = r_a ^ r_b;
            2'b01:   w_alu = r_a + r_b;
            default: w_alu = ~(r_a & r_b);
        endcase
    end

    assign w_rsp_fire = (r_state == StResp) && i_rsp_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_prio     <= RR_INIT;
            r_op       <= 2'b00;
            r_a        <= 8'h00;
            r_b        <= 8'h00;
            r_id       <= 1'b0;
            r_rsp_data <= 8'h00;
            r_rsp_id   <= 1'b0;
            r_done_cnt <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant0) begin
                r_op <= i_req0_opcode;
                r_a  <= i_req0_a;
                r_b  <= i_req0_b;
                r_id <= 1'b0;
            end else if (w_grant1) begin
                r_op <= i_req1_opcode;
                r_a  <= i_req1_a;
                r_b  <= i_req1_b;
                r_id <= 1'b1;
            end
            if (r_state == StExec) begin
                r_rsp_data <= w_alu;
                r_rsp_id   <= r_id;
            end
            if (w_rsp_fire) begin
                r_prio     <= ~r_rsp_id;
                r_done_cnt <= r_done_cnt + 16'd1;
            end
        end
    end

    // Readys are gated by reset so nothing is acknowledged while it is held.
    assign o_req0_ready = w_grant0 & i_rst_n;
    assign o_req1_ready = w_grant1 & i_rst_n;
    assign o_rsp_valid  = (r_state == StResp);
    assign o_rsp_id     = r_rsp_id;
    assign o_rsp_data   = r_rsp_data;
    assign o_busy       = (r_state != StIdle);
    assign o_done_cnt   = r_done_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; inputs driven and outputs sampled on negedge.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_opcode, req1_opcode;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [7:0]  rsp_data;
    logic        busy;
    logic [15:0] done_cnt;

    int checks = 0;
    int errors = 0;

    alu_arbiter dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req0_valid  (req0_valid),
        .o_req0_ready  (req0_ready),
        .i_req0_opcode (req0_opcode),
        .i_req0_a      (req0_a),
        .i_req0_b      (req0_b),
        .i_req1_valid  (req1_valid),
        .o_req1_ready  (req1_ready),
        .i_req1_opcode (req1_opcode),
        .i_req1_a      (req1_a),
        .i_req1_b      (req1_b),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_id      (rsp_id),
        .o_rsp_data    (rsp_data),
        .o_busy        (busy),
        .o_done_cnt    (done_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered on a negedge with the FSM idle; returns on the negedge after completion.
    task automatic run_op(input logic id, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp,
                          input logic [15:0] exp_cnt);
        if (id) begin
            req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b;
        end
        rsp_ready = 1'b1;
        #1;
        check("grant_ready", id ? req1_ready : req0_ready, 16'd1);
        check("grant_other", id ? req0_ready : req1_ready, 16'd0);
        @(negedge clk);
        // Disturb the inputs after grant; the in-flight result must not change.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
        req0_opcode = ~op; req1_opcode = ~op;
        check("exec_rsp_valid", rsp_valid, 16'd0);
        check("exec_busy", busy, 16'd1);
        @(negedge clk);
        check("resp_valid", rsp_valid, 16'd1);
        check("resp_data", rsp_data, exp);
        check("resp_id", rsp_id, id);
        @(negedge clk);
        check("done_cnt", done_cnt, exp_cnt);
        check("idle_busy", busy, 16'd0);
    endtask

    logic eid;

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_opcode = 2'b00; req1_opcode = 2'b00;
        req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
        rsp_ready = 1'b0;
        #3;
        check("rst_rsp_valid", rsp_valid, 16'd0);
        check("rst_rsp_data", rsp_data, 16'h00);
        check("rst_rsp_id", rsp_id, 16'd0);
        check("rst_done_cnt", done_cnt, 16'd0);
        check("rst_busy", busy, 16'd0);
        check("rst_ready0", req0_ready, 16'd0);
        check("rst_ready1", req1_ready, 16'd0);

        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        run_op(1'b0, 2'b00, 8'hA5, 8'h0F, 8'hAA, 16'd1);
        run_op(1'b1, 2'b01, 8'hFF, 8'h01, 8'h00, 16'd2);
        run_op(1'b1, 2'b01, 8'h7F, 8'h01, 8'h80, 16'd3);
        run_op(1'b0, 2'b10, 8'hF0, 8'hCC, 8'h3F, 16'd4);
        run_op(1'b0, 2'b11, 8'h00, 8'h00, 8'hFF, 16'd5);

        // rsp_ready while idle is ignored.
        rsp_ready = 1'b1;
        @(negedge clk);
        check("idle_rspready_valid", rsp_valid, 16'd0);
        check("idle_rspready_cnt", done_cnt, 16'd5);

        // Back-pressure: hold rsp_ready low for 5 RESP cycles.
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_opcode = 2'b00; req0_a = 8'h12; req0_b = 8'h34;
        #1;
        check("stall_grant", req0_ready, 16'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_opcode = 2'b01; req1_a = 8'h55; req1_b = 8'h66;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", rsp_valid, 16'd1);
            check("stall_data", rsp_data, 16'h26);
            check("stall_busy", busy, 16'd1);
            check("stall_no_grant", req1_ready, 16'd0);
            @(negedge clk);
        end
        // Requester 1 withdraws without ever being granted.
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        check("stall6_valid", rsp_valid, 16'd1);
        check("stall6_cnt", done_cnt, 16'd5);
        @(negedge clk);
        check("stall_done_cnt", done_cnt, 16'd6);
        check("stall_idle", busy, 16'd0);

        // Reset pulse while in RESP discards the operation.
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_opcode = 2'b01; req1_a = 8'h01; req1_b = 8'h02;
        #1;
        check("rstresp_grant", req1_ready, 16'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        check("rstresp_valid_pre", rsp_valid, 16'd1);
        check("rstresp_data_pre", rsp_data, 16'h03);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstresp_valid", rsp_valid, 16'd0);
        check("rstresp_cnt", done_cnt, 16'd0);
        check("rstresp_data", rsp_data, 16'h00);
        check("rstresp_busy", busy, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters valid continuously: grants alternate starting at RR_INIT.
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_opcode = 2'b00; req0_a = 8'hF0; req0_b = 8'h0F;
        req1_valid = 1'b1; req1_opcode = 2'b01; req1_a = 8'h10; req1_b = 8'h20;
        for (int k = 0; k < 4; k++) begin
            eid = k[0];
            #1;
            check("rr_ready0", req0_ready, {15'd0, ~eid});
            check("rr_ready1", req1_ready, {15'd0, eid});
            @(negedge clk);
            check("rr_exec_ready0", req0_ready, 16'd0);
            check("rr_exec_ready1", req1_ready, 16'd0);
            @(negedge clk);
            check("rr_id", rsp_id, {15'd0, eid});
            check("rr_data", rsp_data, eid ? 16'h30 : 16'hFF);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr_cnt", done_cnt, 16'd4);

        // Counter wrap: preload near the top, then complete two operations.
        force dut.r_done_cnt = 16'hFFFE;
        #1;
        release dut.r_done_cnt;
        #1;
        check("wrap_preload", done_cnt, 16'hFFFE);
        @(negedge clk);
        run_op(1'b0, 2'b01, 8'h01, 8'h01, 8'h02, 16'hFFFF);
        run_op(1'b0, 2'b00, 8'h3C, 8'hC3, 8'hFF, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0: requester holding priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low; one clock, reset asynchronous active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_opcode  input  2  requester 0 opcode: 00 XOR, 01 ADD, 10/11 NAND.
REQ-007 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_opcode, req1_a, req1_b: same widths and meaning for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  requester that issued the result.
REQ-012 rsp_data  output  8  ALU result.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done_cnt  output  16  count of completed responses.

Function
REQ-015 Block SHALL share one ALU (XOR / 8-bit ADD, carry discarded / NAND) between two requesters.
REQ-016 FSM states SHALL be IDLE, EXEC, RESP.
REQ-017 IDLE: no valid -> stay IDLE; one valid -> grant it; both valid -> grant prio requester.
REQ-018 Grant: winner's reqN_ready SHALL be high combinationally in that IDLE cycle only; the loser's ready SHALL be low.
REQ-019 reqN_ready SHALL never be high outside IDLE or without the matching reqN_valid.
REQ-020 On grant, opcode, a, b and id SHALL be latched; FSM -> EXEC.
REQ-021 EXEC: ALU output of latched operands SHALL be registered into rsp_data, rsp_id set; FSM -> RESP.
REQ-022 RESP: rsp_valid high; rsp_data and rsp_id SHALL hold stable until rsp_valid and rsp_ready both high.
REQ-023 Response handshake: FSM -> IDLE, prio <= other requester (~rsp_id), done_cnt increments.
REQ-024 Latency: grant at cycle N -> rsp_valid first high at cycle N+2; minimum 3 cycles per operation.
REQ-025 rsp_ready high while rsp_valid low SHALL be ignored.
REQ-026 done_cnt SHALL wrap 0xFFFF -> 0x0000.
REQ-027 Requester dropping valid without grant: no side effects; inputs not latched.
REQ-028 Input changes after grant SHALL NOT affect the in-flight result.
REQ-029 Single-requester traffic SHALL be served back-to-back; prio toggle does not block it.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, rsp_valid 0, rsp_data 0x00, rsp_id 0, done_cnt 0, busy 0, both readys 0, prio RR_INIT.
REQ-031 Reset during EXEC or RESP SHALL discard the in-flight operation without a response or a count increment.
REQ-032 First grant is allowed on the first rising edge after rst_n deasserts.

Verification
REQ-033 req0 XOR a=0xA5 b=0x0F, rsp_ready=1 -> rsp_data 0xAA, rsp_id 0, two cycles after grant, done_cnt 1.
REQ-034 req1 ADD 0xFF+0x01 -> rsp_data 0x00; ADD 0x7F+0x01 -> 0x80; opcode 10, 0xF0/0xCC -> 0x3F; opcode 11, 0x00/0x00 -> 0xFF.
REQ-035 Both valid continuously, RR_INIT=0 -> grant order 0,1,0,1; rsp_id alternates; no ready overlap.
REQ-036 rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_data stable; no new grant; busy 1; completion on 6th cycle.
REQ-037 rst_n pulsed low in RESP -> rsp_valid 0 asynchronously, done_cnt 0, next grant goes to RR_INIT.
REQ-038 65536 completions from done_cnt 0 -> done_cnt wraps to 0x0000.
